// File: rtl/object_placement_pkg.sv
// Shared types and default constants for the object placement controller.
// Holds the FSM state enum, the 11-bit coordinate type and a tile helper.
package object_placement_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_READY
  } state_t;

  typedef logic [10:0] coord_t;

  localparam int DEF_NUM_LEVELS = 4;
  localparam int DEF_GRID_COLS  = 9;
  localparam int DEF_GRID_ROWS  = 7;
  localparam int DEF_TILE_SIZE  = 64;
  localparam int DEF_ORIGIN_X   = 15;
  localparam int DEF_ORIGIN_Y   = 48;

  function automatic coord_t tile_to_px(
    input logic [4:0] idx,
    input int         tile,
    input int         origin
  );
    return coord_t'(int'(idx) * tile + origin);
  endfunction

endpackage

// File: rtl/key_rise_detect.sv
// Rising-edge detector for a level-type key.
// A held key yields exactly one rise_out cycle.
module key_rise_detect (
  input  logic clk,
  input  logic resetN,
  input  logic key_in,
  output logic rise_out
);

  logic key_prev;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) key_prev <= 1'b0;
    else         key_prev <= key_in;
  end

  assign rise_out = key_in & ~key_prev;

endmodule

// File: rtl/object_placement_controller.sv
// Captures NUM_LEVELS random grid positions and serves them by level number.
// Define OBJECT_PLACEMENT_DUP_CHECK_EN to reject repeated (col,row) samples.
module object_placement_controller
  import object_placement_pkg::*;
#(
  parameter int NUM_LEVELS = DEF_NUM_LEVELS,
  parameter int GRID_COLS  = DEF_GRID_COLS,
  parameter int GRID_ROWS  = DEF_GRID_ROWS,
  parameter int TILE_SIZE  = DEF_TILE_SIZE,
  parameter int ORIGIN_X   = DEF_ORIGIN_X,
  parameter int ORIGIN_Y   = DEF_ORIGIN_Y
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        enter_is_presed,
  input  logic        reset,
  input  logic [2:0]  level_select,
  input  logic [4:0]  random_num1,
  input  logic [4:0]  random_num2,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [2:0]  bitMap_sel,
  output logic        busy,
  output logic        placement_valid,
  output logic        sample_reject
);

  localparam int SW = $clog2(NUM_LEVELS);
  localparam logic [5:0] COLS6 = 6'(GRID_COLS);
  localparam logic [5:0] ROWS6 = 6'(GRID_ROWS);
  localparam logic [SW-1:0] LAST = SW'(NUM_LEVELS - 1);

  state_t              state;
  logic                pending;
  logic [SW-1:0]       slot_idx;
  logic [NUM_LEVELS-1:0] slot_vld;
  coord_t              slot_x [NUM_LEVELS];
  coord_t              slot_y [NUM_LEVELS];

  logic          press;
  logic          in_range;
  logic          dup_hit;
  logic          accept;
  logic          restart;
  logic          sel_ok;
  logic [SW-1:0] sel_idx;

  key_rise_detect u_key (
    .clk      (clk),
    .resetN   (resetN),
    .key_in   (enter_is_presed),
    .rise_out (press)
  );

  assign in_range = ({1'b0, random_num1} < COLS6) &&
                    ({1'b0, random_num2} < ROWS6);

`ifdef OBJECT_PLACEMENT_DUP_CHECK_EN
  logic [4:0] slot_col [NUM_LEVELS];
  logic [4:0] slot_row [NUM_LEVELS];

  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (slot_vld[i] &&
          slot_col[i] == random_num1 &&
          slot_row[i] == random_num2)
        dup_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_LEVELS; i++) begin
        slot_col[i] <= '0;
        slot_row[i] <= '0;
      end
    end else if (state == S_CAPTURE && accept && !restart) begin
      slot_col[slot_idx] <= random_num1;
      slot_row[slot_idx] <= random_num2;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  assign accept  = pending & in_range & ~dup_hit;
  assign restart = press & reset;
  assign sel_ok  = (level_select != 3'd0) &&
                   ({1'b0, level_select} <= 4'(NUM_LEVELS));
  assign sel_idx = SW'(level_select - 3'd1);

  assign busy            = (state == S_CAPTURE);
  assign placement_valid = (state == S_READY);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= S_IDLE;
      pending       <= 1'b0;
      slot_idx      <= '0;
      slot_vld      <= '0;
      topLeftX      <= '0;
      topLeftY      <= '0;
      bitMap_sel    <= '0;
      sample_reject <= 1'b0;
      for (int i = 0; i < NUM_LEVELS; i++) begin
        slot_x[i] <= '0;
        slot_y[i] <= '0;
      end
    end else begin
      sample_reject <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (press) begin
            slot_idx <= '0;
            pending  <= 1'b0;
            state    <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (restart) begin
            state    <= S_IDLE;
            pending  <= 1'b0;
            slot_vld <= '0;
          end else begin
            if (accept) begin
              slot_x[slot_idx]   <= tile_to_px(random_num1, TILE_SIZE, ORIGIN_X);
              slot_y[slot_idx]   <= tile_to_px(random_num2, TILE_SIZE, ORIGIN_Y);
              slot_vld[slot_idx] <= 1'b1;
              pending            <= 1'b0;
              slot_idx           <= slot_idx + SW'(1);
              if (slot_idx == LAST) state <= S_READY;
            end else if (pending) begin
              sample_reject <= 1'b1;
            end
            // a fresh press queues the next sample
            if (press) pending <= 1'b1;
          end
        end
        S_READY: begin
          if (restart) begin
            state    <= S_IDLE;
            pending  <= 1'b0;
            slot_vld <= '0;
          end else if (sel_ok) begin
            topLeftX   <= slot_x[sel_idx];
            topLeftY   <= slot_y[sel_idx];
            bitMap_sel <= level_select - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/object_placement_controller.md
OBJECT_PLACEMENT_CONTROLLER -- requirements
Module: object_placement_controller

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low; ports are clk and resetN.
REQ-002 Parameters SHALL be (name, default, meaning):
- NUM_LEVELS, 4: placement slots, range 2..8.
- GRID_COLS, 9: valid column count, at most 32.
- GRID_ROWS, 7: valid row count, at most 32.
- TILE_SIZE, 64: pixels per tile.
- ORIGIN_X, 15: pixel X of column 0.
- ORIGIN_Y, 48: pixel Y of row 0.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- resetN, in, 1: async active-low reset.
- enter_is_presed, in, 1: level-type key.
- reset, in, 1: qualifier that makes an enter press restart the block.
- level_select, in, 3: 1-based level number.
- random_num1, in, 5: column sample.
- random_num2, in, 5: row sample.
- topLeftX, out, 11: selected object X.
- topLeftY, out, 11: selected object Y.
- bitMap_sel, out, 3: zero-based slot index.
- busy, out, 1: high in CAPTURE.
- placement_valid, out, 1: high in READY.
- sample_reject, out, 1: one-cycle pulse per rejected sample.

Function
REQ-004 A press SHALL be the rising edge enter_is_presed & !enter_prev, where enter_prev is a register of enter_is_presed; holding the key gives exactly one press.
REQ-005 The state machine SHALL have three states: IDLE, CAPTURE and READY.
REQ-006 In IDLE, a press SHALL clear slot_idx to 0 and pending, then enter CAPTURE on the next cycle.
REQ-007 In CAPTURE, a press SHALL set pending; no sample is taken while pending is low.
REQ-008 While pending is high, each cycle SHALL evaluate (random_num1, random_num2) as follows:
- Accept when col < GRID_COLS, row < GRID_ROWS and the duplicate check per REQ-017 passes.
- Reject otherwise: pulse sample_reject and keep pending high so the next cycle is retried.
REQ-009 On accept, the block SHALL store X = col*TILE_SIZE + ORIGIN_X and Y = row*TILE_SIZE + ORIGIN_Y, each truncated to 11 bits, in slot slot_idx, clear pending, and increment slot_idx.
REQ-010 Acceptance into slot NUM_LEVELS-1 SHALL move the block to READY on the next cycle.
REQ-011 In READY, when 1 <= level_select <= NUM_LEVELS, the outputs SHALL update one cycle later to:
- topLeftX and topLeftY from slot level_select-1.
- bitMap_sel = level_select-1.
REQ-012 In READY, an out-of-range level_select (0 or greater than NUM_LEVELS) SHALL leave topLeftX, topLeftY and bitMap_sel holding their previous values.
REQ-013 In CAPTURE or READY, a press with reset high SHALL return the block to IDLE, clear pending and invalidate every slot; this has priority over a same-cycle accept.
REQ-014 In IDLE and CAPTURE, topLeftX, topLeftY and bitMap_sel SHALL hold their previous values.
REQ-015 busy SHALL equal (state == CAPTURE); placement_valid SHALL equal (state == READY).

Reset
REQ-016 On resetN low, the block SHALL immediately force the following, asynchronously:
- topLeftX = 0, topLeftY = 0, bitMap_sel = 0.
- busy = 0, placement_valid = 0, sample_reject = 0.
- state = IDLE, slot_idx = 0, pending = 0, enter_prev = 0.
- All slot-valid bits = 0.

Configuration
REQ-017 Duplicate checking SHALL be controlled by the macro OBJECT_PLACEMENT_DUP_CHECK_EN:
- Defined: a sample whose (col, row) equals any valid, already-captured slot is rejected.
- Undefined: only the range check applies, and duplicates are accepted.

Structure
REQ-018 Package object_placement_pkg SHALL hold the state enum, default parameter constants and the 11-bit coordinate typedef.
REQ-019 Press detection SHALL be a sub-module named key_rise_detect (ports clk, resetN, key_in, rise_out); the slot table SHALL be flops, with no RAM.

Verification
REQ-020 Reset, press, then samples (2,3), (0,0), (8,6), (4,4) each on its own press -> placement_valid = 1; level_select = 1 gives (143,240) and bitMap_sel = 0; level_select = 4 gives (271,304) and bitMap_sel = 3.
REQ-021 In CAPTURE, hold the key with samples (9,3) then (31,0) then (1,1) -> sample_reject pulses twice; slot 0 = (79,112); a single press only.
REQ-022 With DUP_CHECK_EN defined: slot 0 = (2,3), then present (2,3) then (5,5) for slot 1 -> one reject pulse; slot 1 = (335,368). With the macro undefined -> slot 1 = (143,240).
REQ-023 In READY, change level_select to 0 -> outputs unchanged; then to 2 -> outputs switch after exactly one cycle.
REQ-024 Assert reset together with a press in the same cycle as an accept in CAPTURE -> the block is in IDLE next cycle; the slot is not written; placement_valid = 0.
REQ-025 Pull resetN low mid-CAPTURE -> all outputs are 0 immediately without a clock edge; after release, a press is required to leave IDLE.
